rd_unpack: RTL and testbench

//   Read-side consumer of the 1-bit-pointer MCP FIFO control (rrdy/rget/rptr).

---
 rtl/rd_unpack_if.sv | 23 ++
 rtl/rd_unpack.sv | 91 +++++++++
 tb/tb_rd_unpack.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rd_unpack_if.sv
// Read-side word fetch and narrow-beat stream between FIFO read control, RAM and datapath.
interface rd_unpack_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 8
);
  logic          rrdy;
  logic [DW-1:0] rdata;
  logic          rget;
  logic [LW-1:0] odata;
  logic          ovalid;
  logic          oready;
  logic          olast;

  modport master (
    input  rrdy, rdata, oready,
    output rget, odata, ovalid, olast
  );

  modport slave (
    output rrdy, rdata, oready,
    input  rget, odata, ovalid, olast
  );
endinterface

// File: rtl/rd_unpack.sv
// Pops DW-bit words from the MCP FIFO read port and streams them as RATIO
// narrow valid/ready beats, reloading on the last beat without a bubble.
module rd_unpack #(
  parameter int unsigned DW        = 32,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CW        = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             flush,
  rd_unpack_if.master      bus,
  output logic [CW-1:0]    wcnt
);

  localparam int unsigned LW   = DW / RATIO;
  localparam int unsigned LIW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LIW-1:0] LAST = LIW'(RATIO - 1);

  generate
    if ((RATIO == 0) || (DW % RATIO != 0)) begin : g_bad_ratio
      $error("rd_unpack: DW must be a non-zero multiple of RATIO");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q;
  logic [DW-1:0]  hold_q;
  logic [LIW-1:0] lane_q;
  logic           last_lane_c;
  logic           load_c;

  // Map a logical beat index to its lane of the word.
  function automatic logic [LW-1:0] lane_sel(input logic [DW-1:0] w,
                                             input logic [LIW-1:0] idx);
    int unsigned phys;
    phys = MSB_FIRST ? (RATIO - 32'd1 - 32'(idx)) : 32'(idx);
    return LW'(w >> (phys * LW));
  endfunction

  // Fetch from IDLE, or reload as the final beat is accepted; flush and reset block the pop.
  always_comb begin
    last_lane_c = (lane_q == LAST);
    load_c      = 1'b0;
    if (rrst_n && !flush && bus.rrdy) begin
      if (state_q == IDLE) begin
        load_c = 1'b1;
      end else if (bus.oready && last_lane_c) begin
        load_c = 1'b1;
      end
    end
    bus.rget = load_c;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      lane_q     <= '0;
      bus.ovalid <= 1'b0;
      bus.olast  <= 1'b0;
      bus.odata  <= '0;
      wcnt       <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      bus.ovalid <= 1'b0;
      bus.olast  <= 1'b0;
    end else if (load_c) begin
      state_q    <= BUSY;
      hold_q     <= bus.rdata;
      lane_q     <= '0;
      wcnt       <= wcnt + CW'(1);
      bus.ovalid <= 1'b1;
      bus.olast  <= (RATIO == 1);
      bus.odata  <= lane_sel(bus.rdata, '0);
    end else if ((state_q == BUSY) && bus.oready) begin
      if (!last_lane_c) begin
        lane_q    <= lane_q + LIW'(1);
        bus.odata <= lane_sel(hold_q, lane_q + LIW'(1));
        bus.olast <= ((lane_q + LIW'(1)) == LAST);
      end else begin
        state_q    <= IDLE;
        bus.ovalid <= 1'b0;
        bus.olast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rd_unpack.sv
// Directed bench for rd_unpack: LSB-first/CW=16 and MSB-first/CW=4 instances.
module tb_rd_unpack;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        flush0 = 1'b0;
  logic        flush1 = 1'b0;
  logic [15:0] wcnt0;
  logic [3:0]  wcnt1;
  int          checks = 0;
  int          errors = 0;

  rd_unpack_if #(.DW(32), .LW(8)) bus0 ();
  rd_unpack_if #(.DW(32), .LW(8)) bus1 ();

  rd_unpack #(.DW(32), .RATIO(4), .MSB_FIRST(1'b0), .CW(16)) u0 (
    .rclk(rclk), .rrst_n(rrst_n), .flush(flush0), .bus(bus0), .wcnt(wcnt0)
  );

  rd_unpack #(.DW(32), .RATIO(4), .MSB_FIRST(1'b1), .CW(4)) u1 (
    .rclk(rclk), .rrst_n(rrst_n), .flush(flush1), .bus(bus1), .wcnt(wcnt1)
  );

  always #5 rclk = ~rclk;

  // Present a word on bus0 for one cycle; returns one cycle later with beat 0 showing.
  task automatic load0(input logic [31:0] w);
    @(negedge rclk);
    bus0.rdata  = w;
    bus0.rrdy   = 1'b1;
    bus0.oready = 1'b1;
    @(negedge rclk);
    bus0.rrdy = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    bus0.rrdy = 1'b1; bus0.rdata = 32'h12345678; bus0.oready = 1'b1;
    bus1.rrdy = 1'b1; bus1.rdata = 32'h12345678; bus1.oready = 1'b1;
    rrst_n = 1'b0;
    repeat (2) @(negedge rclk);
    #1;
    checks++; if (bus0.rget !== 1'b0) begin errors++; $display("FAIL reset_rget: got %b expected 0", bus0.rget); end
    checks++; if ({bus0.ovalid, bus0.olast} !== 2'b00) begin errors++; $display("FAIL reset_valid_last: got %b expected 00", {bus0.ovalid, bus0.olast}); end
    checks++; if (bus0.odata !== 8'h00) begin errors++; $display("FAIL reset_odata: got %h expected 00", bus0.odata); end
    checks++; if (wcnt0 !== 16'd0) begin errors++; $display("FAIL reset_wcnt: got %0d expected 0", wcnt0); end
    checks++; if (bus1.rget !== 1'b0) begin errors++; $display("FAIL reset_rget1: got %b expected 0", bus1.rget); end
    bus0.rrdy = 1'b0;
    bus1.rrdy = 1'b0;
    rrst_n = 1'b1;
    @(negedge rclk);
  endtask

  task automatic test_basic;
    logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge rclk);
    bus0.rdata = 32'hDDCCBBAA; bus0.rrdy = 1'b1; bus0.oready = 1'b1;
    #1;
    checks++; if (bus0.rget !== 1'b1) begin errors++; $display("FAIL basic_rget: got %b expected 1", bus0.rget); end
    checks++; if (bus0.ovalid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b expected 0", bus0.ovalid); end
    @(negedge rclk);
    bus0.rrdy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus0.ovalid !== 1'b1) begin errors++; $display("FAIL basic_valid%0d: got %b expected 1", i, bus0.ovalid); end
      checks++; if (bus0.odata !== exp_b[i]) begin errors++; $display("FAIL basic_odata%0d: got %h expected %h", i, bus0.odata, exp_b[i]); end
      checks++; if (bus0.olast !== (i == 3)) begin errors++; $display("FAIL basic_olast%0d: got %b expected %b", i, bus0.olast, (i == 3)); end
      checks++; if (bus0.rget !== 1'b0) begin errors++; $display("FAIL basic_rget_beat%0d: got %b expected 0", i, bus0.rget); end
      @(negedge rclk);
      #1;
    end
    checks++; if (bus0.ovalid !== 1'b0) begin errors++; $display("FAIL basic_end_valid: got %b expected 0", bus0.ovalid); end
    checks++; if (wcnt0 !== 16'd1) begin errors++; $display("FAIL basic_wcnt: got %0d expected 1", wcnt0); end
  endtask

  task automatic test_msb_first;
    logic [7:0] exp_b [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    @(negedge rclk);
    bus1.rdata = 32'hDDCCBBAA; bus1.rrdy = 1'b1; bus1.oready = 1'b1;
    #1;
    checks++; if (bus1.rget !== 1'b1) begin errors++; $display("FAIL msb_rget: got %b expected 1", bus1.rget); end
    @(negedge rclk);
    bus1.rrdy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus1.odata !== exp_b[i]) begin errors++; $display("FAIL msb_odata%0d: got %h expected %h", i, bus1.odata, exp_b[i]); end
      checks++; if (bus1.olast !== (i == 3)) begin errors++; $display("FAIL msb_olast%0d: got %b expected %b", i, bus1.olast, (i == 3)); end
      @(negedge rclk);
      #1;
    end
    checks++; if (bus1.ovalid !== 1'b0) begin errors++; $display("FAIL msb_end_valid: got %b expected 0", bus1.ovalid); end
    checks++; if (wcnt1 !== 4'd1) begin errors++; $display("FAIL msb_wcnt: got %0d expected 1", wcnt1); end
  endtask

  task automatic test_backpressure;
    load0(32'hDDCCBBAA);
    checks++; if (bus0.odata !== 8'hAA) begin errors++; $display("FAIL bp_first: got %h expected aa", bus0.odata); end
    @(negedge rclk);
    bus0.oready = 1'b0;
    bus0.rrdy = 1'b1;
    bus0.rdata = 32'h99999999;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({bus0.ovalid, bus0.olast, bus0.odata} !== {2'b10, 8'hBB}) begin errors++; $display("FAIL bp_hold%0d: got v=%b l=%b d=%h expected v=1 l=0 d=bb", k, bus0.ovalid, bus0.olast, bus0.odata); end
      checks++; if (bus0.rget !== 1'b0) begin errors++; $display("FAIL bp_rget%0d: got %b expected 0", k, bus0.rget); end
      @(negedge rclk);
    end
    bus0.oready = 1'b1;
    bus0.rrdy = 1'b0;
    #1;
    checks++; if (bus0.odata !== 8'hBB) begin errors++; $display("FAIL bp_release: got %h expected bb", bus0.odata); end
    @(negedge rclk); #1;
    checks++; if (bus0.odata !== 8'hCC) begin errors++; $display("FAIL bp_cc: got %h expected cc", bus0.odata); end
    @(negedge rclk); #1;
    checks++; if ({bus0.olast, bus0.odata} !== {1'b1, 8'hDD}) begin errors++; $display("FAIL bp_dd: got l=%b d=%h expected l=1 d=dd", bus0.olast, bus0.odata); end
    @(negedge rclk); #1;
    checks++; if (bus0.ovalid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b expected 0", bus0.ovalid); end
    checks++; if (wcnt0 !== 16'd2) begin errors++; $display("FAIL bp_wcnt: got %0d expected 2", wcnt0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    load0(32'hDDCCBBAA);
    repeat (3) @(negedge rclk);
    bus0.rrdy = 1'b1;
    bus0.rdata = 32'h44332211;
    #1;
    checks++; if ({bus0.olast, bus0.odata} !== {1'b1, 8'hDD}) begin errors++; $display("FAIL b2b_dd: got l=%b d=%h expected l=1 d=dd", bus0.olast, bus0.odata); end
    checks++; if (bus0.rget !== 1'b1) begin errors++; $display("FAIL b2b_rget: got %b expected 1", bus0.rget); end
    @(negedge rclk);
    bus0.rrdy = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus0.ovalid, bus0.olast, bus0.odata} !== {1'b1, (i == 3), exp_b[i]}) begin errors++; $display("FAIL b2b_beat%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h", i, bus0.ovalid, bus0.olast, bus0.odata, (i == 3), exp_b[i]); end
      @(negedge rclk);
      #1;
    end
    checks++; if (bus0.ovalid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", bus0.ovalid); end
    checks++; if (wcnt0 !== 16'd4) begin errors++; $display("FAIL b2b_wcnt: got %0d expected 4", wcnt0); end
  endtask

  task automatic test_flush;
    load0(32'hDDCCBBAA);
    repeat (2) @(negedge rclk);
    flush0 = 1'b1;
    bus0.rrdy = 1'b1;
    bus0.rdata = 32'h87654321;
    #1;
    checks++; if (bus0.odata !== 8'hCC) begin errors++; $display("FAIL flush_beat3: got %h expected cc", bus0.odata); end
    checks++; if (bus0.rget !== 1'b0) begin errors++; $display("FAIL flush_rget: got %b expected 0", bus0.rget); end
    @(negedge rclk);
    flush0 = 1'b0;
    #1;
    checks++; if (bus0.ovalid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus0.ovalid); end
    checks++; if (wcnt0 !== 16'd5) begin errors++; $display("FAIL flush_wcnt: got %0d expected 5", wcnt0); end
    checks++; if (bus0.rget !== 1'b1) begin errors++; $display("FAIL flush_refetch: got %b expected 1", bus0.rget); end
    @(negedge rclk);
    bus0.rrdy = 1'b0;
    #1;
    checks++; if ({bus0.ovalid, bus0.olast, bus0.odata} !== {2'b10, 8'h21}) begin errors++; $display("FAIL flush_lane0: got v=%b l=%b d=%h expected v=1 l=0 d=21", bus0.ovalid, bus0.olast, bus0.odata); end
    repeat (3) @(negedge rclk);
    #1;
    checks++; if ({bus0.olast, bus0.odata} !== {1'b1, 8'h87}) begin errors++; $display("FAIL flush_last: got l=%b d=%h expected l=1 d=87", bus0.olast, bus0.odata); end
    @(negedge rclk); #1;
    checks++; if (wcnt0 !== 16'd6) begin errors++; $display("FAIL flush_wcnt_end: got %0d expected 6", wcnt0); end
  endtask

  task automatic test_reset_mid_word;
    load0(32'hCAFEF00D);
    @(negedge rclk);
    bus0.rrdy = 1'b1;
    rrst_n = 1'b0;
    #1;
    checks++; if (bus0.rget !== 1'b0) begin errors++; $display("FAIL rstmid_rget: got %b expected 0", bus0.rget); end
    checks++; if ({bus0.ovalid, bus0.olast, bus0.odata} !== 10'd0) begin errors++; $display("FAIL rstmid_out: got v=%b l=%b d=%h expected all 0", bus0.ovalid, bus0.olast, bus0.odata); end
    checks++; if (wcnt0 !== 16'd0) begin errors++; $display("FAIL rstmid_wcnt: got %0d expected 0", wcnt0); end
    @(negedge rclk);
    bus0.rrdy = 1'b0;
    rrst_n = 1'b1;
  endtask

  task automatic test_wcnt_wrap;
    int n = 0;
    @(negedge rclk);
    bus1.rdata = 32'h5A5A5A5A; bus1.rrdy = 1'b1; bus1.oready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (bus1.rget) n++;
      if (n == 17) break;
      @(negedge rclk);
    end
    @(negedge rclk);
    bus1.rrdy = 1'b0;
    checks++; if (n !== 17) begin errors++; $display("FAIL wrap_fetches: got %0d expected 17", n); end
    repeat (4) @(negedge rclk);
    #1;
    checks++; if (bus1.ovalid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid: got %b expected 0", bus1.ovalid); end
    checks++; if (wcnt1 !== 4'd1) begin errors++; $display("FAIL wrap_wcnt: got %0d expected 1", wcnt1); end
  endtask

  initial begin
    bus0.rrdy = 1'b0; bus0.rdata = '0; bus0.oready = 1'b0;
    bus1.rrdy = 1'b0; bus1.rdata = '0; bus1.oready = 1'b0;
    test_reset();
    test_basic();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_word();
    test_wcnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
